mem_stage: RTL and testbench

//   Fourth pipeline stage of the 32-bit MIPS core. It sits directly downstream of the EX stage: it latches EX

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage_data_mem.sv | 43 ++++
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared control-field indices, bubble constants and pipeline register layouts for the MEM stage.
// Single source of truth for MEMReg/WBReg bit meaning across EX, MEM and WB.
package mem_stage_pkg;

   localparam int MEM_RD = 0;
   localparam int MEM_WR = 1;
   localparam int WB_RW  = 0;
   localparam int WB_M2R = 1;

   localparam logic [3:0] MEMREG_BUBBLE = 4'b0000;
   localparam logic [1:0] WBREG_BUBBLE  = 2'b00;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] outb;
      logic [4:0]  wreg;
      logic [3:0]  memreg;
      logic [1:0]  wbreg;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic [1:0]  wbreg;
      logic        align_err;
   } mem_wb_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX <-> MEM <-> WB signal bundle; master is the EX/hazard/WB side, slave is mem_stage.
// Field names match the legacy MIPS pipeline port names.
interface mem_stage_if;

   logic [31:0] Result;
   logic [31:0] OutB;
   logic [4:0]  WriteReg;
   logic [3:0]  MEMReg;
   logic [1:0]  WBReg;
   logic        Flush;

   logic        MemStall;
   logic [31:0] ALUop_inMEM;
   logic [4:0]  WriteReg_MEM;
   logic        RegWrite_MEM;
   logic [31:0] ReadData_WB;
   logic [31:0] ALUResult_WB;
   logic [4:0]  WriteReg_WB;
   logic [1:0]  WBReg_WB;
   logic [31:0] MUXop_inWB;
   logic        AlignErr;

   modport master (
      output Result, OutB, WriteReg, MEMReg, WBReg, Flush,
      input  MemStall, ALUop_inMEM, WriteReg_MEM, RegWrite_MEM, ReadData_WB,
             ALUResult_WB, WriteReg_WB, WBReg_WB, MUXop_inWB, AlignErr
   );

   modport slave (
      input  Result, OutB, WriteReg, MEMReg, WBReg, Flush,
      output MemStall, ALUop_inMEM, WriteReg_MEM, RegWrite_MEM, ReadData_WB,
             ALUResult_WB, WriteReg_WB, WBReg_WB, MUXop_inWB, AlignErr
   );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM, DEPTH x 32; read data registered, 1 edge, held while en is low.
// Contents are never reset; only the read-data register is.
module data_mem #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = re ? mem_q[addr] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM reg, word load/store, MEM/WB reg; 1 edge to EX/MEM, memops add MEM_LAT edges.
// MemStall holds upstream and the EX/MEM register while a memop counts out its wait cycles.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_stage_if.slave  bus
);

   localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT);

   ex_mem_t          ex_q, ex_d;
   mem_wb_t          wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             memop, mem_wr, bad_addr, stall, commit;
   logic [31:0]      rdata;
   logic             unused_bits;

   always_comb begin
      memop    = ex_q.memreg[MEM_RD] | ex_q.memreg[MEM_WR];
      mem_wr   = ex_q.memreg[MEM_WR];
      bad_addr = misaligned(ex_q.result);
      stall    = memop && (cnt_q != CNT_MAX);
      commit   = !stall;
   end

   always_comb begin
      ex_d  = ex_q;
      wb_d  = wb_q;
      cnt_d = '0;
      if (commit) begin
         ex_d.result = bus.Result;
         ex_d.outb   = bus.OutB;
         ex_d.wreg   = bus.WriteReg;
         ex_d.memreg = bus.Flush ? MEMREG_BUBBLE : bus.MEMReg;
         ex_d.wbreg  = bus.Flush ? WBREG_BUBBLE  : bus.WBReg;
         wb_d.alu       = ex_q.result;
         wb_d.wreg      = ex_q.wreg;
         wb_d.wbreg     = ex_q.wbreg;
         wb_d.align_err = memop & bad_addr;
      end else begin
         // Waiting: WB sees a bubble each stalled cycle, EX/MEM holds.
         cnt_d          = cnt_q + 1'b1;
         wb_d.wbreg     = WBREG_BUBBLE;
         wb_d.align_err = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   // Both MemRead and MemWrite set behaves as a store, so reads require !mem_wr.
   data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (commit),
      .we    (commit & mem_wr & !bad_addr),
      .re    (ex_q.memreg[MEM_RD] & !mem_wr & !bad_addr),
      .addr  (ex_q.result[ADDR_W+1:2]),
      .wdata (ex_q.outb),
      .rdata (rdata)
   );

   assign unused_bits = ^{ex_q.result[31:ADDR_W+2], ex_q.memreg[3:2]};

   assign bus.MemStall     = stall;
   assign bus.ALUop_inMEM  = ex_q.result;
   assign bus.WriteReg_MEM = ex_q.wreg;
   assign bus.RegWrite_MEM = ex_q.wbreg[WB_RW];
   assign bus.ReadData_WB  = rdata;
   assign bus.ALUResult_WB = wb_q.alu;
   assign bus.WriteReg_WB  = wb_q.wreg;
   assign bus.WBReg_WB     = wb_q.wbreg;
   assign bus.MUXop_inWB   = wb_q.wbreg[WB_M2R] ? rdata : wb_q.alu;
   assign bus.AlignErr     = wb_q.align_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with MEM_LAT=2, one with MEM_LAT=0.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_stage_if ifa ();
   mem_stage_if ifb ();

   mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic [3:0] mr, input logic [1:0] wb, input logic [31:0] res,
                          input logic [31:0] od, input logic [4:0] wr, input logic fl);
      ifa.MEMReg = mr; ifa.WBReg = wb; ifa.Result = res;
      ifa.OutB = od; ifa.WriteReg = wr; ifa.Flush = fl;
   endtask

   task automatic drive_b(input logic [3:0] mr, input logic [1:0] wb, input logic [31:0] res,
                          input logic [31:0] od, input logic [4:0] wr);
      ifb.MEMReg = mr; ifb.WBReg = wb; ifb.Result = res;
      ifb.OutB = od; ifb.WriteReg = wr; ifb.Flush = 1'b0;
   endtask

   // Issue one instruction on dut_a, count stall cycles, return once MEM/WB holds it.
   task automatic do_op(input string tag, input logic [3:0] mr, input logic [1:0] wb,
                        input logic [31:0] res, input logic [31:0] od, input logic [4:0] wr,
                        input logic fl_now, input logic fl_stall, input int exp_stall);
      int n;
      drive_a(mr, wb, res, od, wr, fl_now);
      @(negedge clk);
      drive_a(4'b0, 2'b0, 32'h0, 32'h0, 5'd0, fl_stall);
      n = 0;
      while (ifa.MemStall && n < 20) begin
         n++;
         @(negedge clk);
      end
      ifa.Flush = 1'b0;
      check({tag, "_stall_cycles"}, n, exp_stall);
      @(negedge clk);
   endtask

   initial begin
      int pat [6] = '{1, 1, 0, 1, 1, 0};
      drive_a(4'b0, 2'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      drive_b(4'b0, 2'b0, 32'h0, 32'h0, 5'd0);
      #12;
      check("rst_memstall",  ifa.MemStall,    0);
      check("rst_aluop",     ifa.ALUop_inMEM, 0);
      check("rst_muxop",     ifa.MUXop_inWB,  0);
      check("rst_wbreg_wb",  ifa.WBReg_WB,    0);
      check("rst_alignerr",  ifa.AlignErr,    0);
      check("rst_readdata",  ifa.ReadData_WB, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Non-memory instruction
      drive_a(4'b0000, 2'b01, 32'h1234, 32'h0, 5'd3, 1'b0);
      @(negedge clk);
      check("alu_aluop_1edge", ifa.ALUop_inMEM,  32'h1234);
      check("alu_nostall",     ifa.MemStall,     0);
      check("alu_regwrite_mem", ifa.RegWrite_MEM, 1);
      check("alu_wreg_mem",    ifa.WriteReg_MEM, 3);
      drive_a(4'b0, 2'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check("alu_muxop_2edge", ifa.MUXop_inWB,  32'h1234);
      check("alu_wreg_wb",     ifa.WriteReg_WB, 3);
      check("alu_wbreg_wb",    ifa.WBReg_WB,    1);
      check("alu_nostall2",    ifa.MemStall,    0);

      // Store then load
      do_op("sw10", 4'b0010, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 2);
      check("sw10_wbreg_wb", ifa.WBReg_WB, 0);
      do_op("lw10", 4'b0001, 2'b11, 32'h10, 32'h0, 5'd8, 0, 0, 2);
      check("lw10_muxop",  ifa.MUXop_inWB,  32'hDEADBEEF);
      check("lw10_wreg",   ifa.WriteReg_WB, 8);
      check("lw10_align",  ifa.AlignErr,    0);

      // Misaligned accesses
      do_op("lw13", 4'b0001, 2'b11, 32'h13, 32'h0, 5'd9, 0, 0, 2);
      check("lw13_alignerr", ifa.AlignErr,    1);
      check("lw13_readdata", ifa.ReadData_WB, 0);
      do_op("sw12", 4'b0010, 2'b00, 32'h12, 32'h00000BAD, 5'd0, 0, 0, 2);
      check("sw12_alignerr", ifa.AlignErr, 1);
      do_op("lw10b", 4'b0001, 2'b11, 32'h10, 32'h0, 5'd8, 0, 0, 2);
      check("lw10_after_misaligned", ifa.MUXop_inWB, 32'hDEADBEEF);

      // Index wraps modulo DEPTH
      do_op("sw400", 4'b0010, 2'b00, 32'h400, 32'hA5A5A5A5, 5'd0, 0, 0, 2);
      do_op("lw000", 4'b0001, 2'b11, 32'h000, 32'h0, 5'd4, 0, 0, 2);
      check("wrap_readback", ifa.MUXop_inWB, 32'hA5A5A5A5);

      // Flush on capture, flush ignored while stalling
      do_op("sw20", 4'b0010, 2'b00, 32'h20, 32'h11111111, 5'd0, 0, 0, 2);
      do_op("sw20_flushed", 4'b0010, 2'b01, 32'h20, 32'h00000001, 5'd4, 1, 0, 0);
      check("flushed_wbreg_wb", ifa.WBReg_WB, 0);
      do_op("lw20", 4'b0001, 2'b11, 32'h20, 32'h0, 5'd5, 0, 0, 2);
      check("flush_prior_value", ifa.MUXop_inWB, 32'h11111111);
      do_op("sw24_flush_in_stall", 4'b0010, 2'b00, 32'h24, 32'h00000077, 5'd0, 0, 1, 2);
      do_op("lw24", 4'b0001, 2'b11, 32'h24, 32'h0, 5'd5, 0, 0, 2);
      check("stall_flush_ignored", ifa.MUXop_inWB, 32'h00000077);

      // MemRead and MemWrite together behave as a store
      do_op("rw28", 4'b0011, 2'b00, 32'h28, 32'h00000055, 5'd0, 0, 0, 2);
      check("rw28_readdata", ifa.ReadData_WB, 0);
      do_op("lw28", 4'b0001, 2'b11, 32'h28, 32'h0, 5'd6, 0, 0, 2);
      check("rw28_stored", ifa.MUXop_inWB, 32'h00000055);

      // Back-to-back loads with MEM_LAT=2: no dead cycle between them
      drive_a(4'b0001, 2'b11, 32'h10, 32'h0, 5'd9, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("b2b_stall_%0d", i), ifa.MemStall, pat[i]);
         if (i == 3) check("b2b_first_data", ifa.MUXop_inWB, 32'hDEADBEEF);
      end
      drive_a(4'b0, 2'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check("b2b_second_data", ifa.MUXop_inWB,  32'hDEADBEEF);
      check("b2b_second_wreg", ifa.WriteReg_WB, 9);

      // Reset in the middle of a store's stall
      do_op("sw30", 4'b0010, 2'b00, 32'h30, 32'h30303030, 5'd0, 0, 0, 2);
      drive_a(4'b0010, 2'b01, 32'h30, 32'hFFFFFFFF, 5'd7, 1'b0);
      @(negedge clk);
      check("rstmid_stall_before", ifa.MemStall, 1);
      drive_a(4'b0, 2'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_memstall", ifa.MemStall,     0);
      check("rstmid_aluop",    ifa.ALUop_inMEM,  0);
      check("rstmid_regwrite", ifa.RegWrite_MEM, 0);
      check("rstmid_wbreg_wb", ifa.WBReg_WB,     0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("lw30", 4'b0001, 2'b11, 32'h30, 32'h0, 5'd2, 0, 0, 2);
      check("rstmid_word_kept", ifa.MUXop_inWB, 32'h30303030);

      // MEM_LAT=0: stores and back-to-back loads never stall
      drive_b(4'b0010, 2'b00, 32'h4, 32'h0000CAFE, 5'd0);
      @(negedge clk);
      check("lat0_sw4_nostall", ifb.MemStall, 0);
      drive_b(4'b0010, 2'b00, 32'h8, 32'h0000BEEF, 5'd0);
      @(negedge clk);
      check("lat0_sw8_nostall", ifb.MemStall, 0);
      drive_b(4'b0001, 2'b11, 32'h4, 32'h0, 5'd10);
      @(negedge clk);
      check("lat0_lw4_nostall", ifb.MemStall, 0);
      drive_b(4'b0001, 2'b11, 32'h8, 32'h0, 5'd11);
      @(negedge clk);
      check("lat0_lw8_nostall", ifb.MemStall, 0);
      check("lat0_lw4_data",    ifb.MUXop_inWB, 32'h0000CAFE);
      drive_b(4'b0, 2'b0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      check("lat0_lw8_data",    ifb.MUXop_inWB,  32'h0000BEEF);
      check("lat0_lw8_wreg",    ifb.WriteReg_WB, 11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
